rx_frame_sequencer: RTL and testbench
=====================================

# rx_frame_sequencer

Upstream control stage for the rx_controller 16:1 byte mux. Starts on a frame-start handshake and steps the mux `sel` through the frame bytes in datain_1-first order (sel 4'hF down to 16-NUM_BYTES). It emits byte_valid, byte_first and byte_last strobes aligned with the mux's registered `dataout`. It optionally accumulates an XOR checksum of the bytes it reads back from the mux output.

## Interface
Parameters:
- NUM_BYTES, 16, bytes per frame; legal 1..16; outside range is an elaboration error

Ports:
- clk  in  1  sole clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  start request; accepted only when frame_ready=1
- frame_ready  out  1  high only in IDLE
- byte_en  in  1  pacing strobe; one byte issued per SEND cycle with byte_en=1
- abort  in  1  synchronous abort of the current frame
- sel  out  4  mux select; registered
- byte_valid  out  1  mux dataout holds an issued byte this cycle
- byte_first  out  1  with byte_valid: first byte (datain_1)
- byte_last  out  1  with byte_valid: byte NUM_BYTES
- frame_done  out  1  one-cycle pulse after the last byte_valid
- seq_err  out  1  sticky: frame_start seen while frame_ready=0
- err_clr  in  1  clears seq_err
- mux_data  in  8  mux dataout fed back; used only with checksum
- frame_chk  out  8  XOR of frame bytes; valid on frame_done

## Operation
- Reset values:
  - state IDLE, sel=4'hF, cnt=0
  - byte_valid, byte_first, byte_last, frame_done, seq_err = 0
  - frame_chk = 8'h00
  - frame_ready = 1
- States:
  - IDLE: frame_start → SEND; sel=4'hF, cnt=0, checksum cleared.
  - SEND: if byte_en=1 and abort=0, issue the current sel byte. If cnt==NUM_BYTES-1 → DRAIN; otherwise cnt+1, sel-1. If byte_en=0, hold sel and cnt.
  - DRAIN: one cycle; the last byte is on dataout → DONE.
  - DONE: frame_done=1 → IDLE.
- Strobes: byte_valid/first/last are registered one cycle after the issue cycle. byte_first when cnt==0 at issue; byte_last when cnt==NUM_BYTES-1.
- sel is held at its issued value until the next issue, so dataout stays stable across byte_en gaps.
- NUM_BYTES=1: byte_first and byte_last assert together.
- abort, in any non-IDLE state:
  - next state is IDLE and sel=4'hF.
  - no issue occurs in the abort cycle.
  - a byte_valid already high in the abort cycle is not retracted.
  - no frame_done for the aborted frame.
- abort in IDLE has no effect.
- abort and frame_start in the same IDLE cycle: frame_start wins.
- frame_start while not IDLE: ignored and seq_err set. err_clr and a set event in the same cycle: set wins.
- cnt is 4 bits and never wraps; sel is never decremented below 16-NUM_BYTES.

## Timing
- Mux latency is 1 cycle; the sequencer adds 1 cycle from frame_start to the first sel.
- frame_start at cycle 0 with byte_en held high:
  - sel=4'hF in cycle 1
  - byte_valid in cycles 2..NUM_BYTES+1
  - frame_done in cycle NUM_BYTES+2
  - frame_ready in cycle NUM_BYTES+3
- Back-to-back frames: next frame_start is accepted at cycle NUM_BYTES+3.
- Each byte_en=0 cycle in SEND adds exactly one cycle of latency.

## Configuration
- RX_SEQ_CHECKSUM_EN defined: frame_chk XOR-accumulates mux_data on every byte_valid cycle. It is cleared on frame_start acceptance and held from frame_done until the next start.
- RX_SEQ_CHECKSUM_EN undefined: frame_chk is tied to 8'h00 and mux_data is unused.

## Structure
- Package rx_ctrl_pkg:
  - state enum (IDLE, SEND, DRAIN, DONE)
  - SEL_FIRST=4'hF
  - BYTE_W=8
- Sub-module rx_seq_chk (checksum accumulator) is instantiated only under RX_SEQ_CHECKSUM_EN.

## Test plan
- Reset mid-SEND (rst_n low at cycle 5): outputs return to reset values immediately; frame_ready=1 after release.
- NUM_BYTES=16, byte_en=1, datain_k=k: byte_valid cycles 2..17 show data 1..16; first at cycle 2, last at cycle 17, frame_done at cycle 18.
- NUM_BYTES=4, byte_en toggling 1,0,1,0…: sel sequence F,E,D,C, each held for 2 cycles; 4 byte_valid pulses; frame_done 1 cycle after the 4th.
- abort during 3rd byte issue: no 4th byte_valid; no frame_done; sel=F and frame_ready=1 the next cycle.
- frame_start during SEND: seq_err=1 and the frame is unaffected; err_clr pulse → seq_err=0.
- RX_SEQ_CHECKSUM_EN, NUM_BYTES=3, bytes 8'hA5, 8'h0F, 8'hFF: frame_chk=8'h55 on frame_done.

Source files
------------

// File: rtl/rx_ctrl_pkg.sv
// ============================================================================
// Module   : rx_ctrl_pkg
// Purpose  : Shared types and constants for the rx_controller frame sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] SEL_FIRST = 4'hF;
  localparam int         BYTE_W    = 8;

endpackage

`default_nettype wire

// File: rtl/rx_seq_chk.sv
// ============================================================================
// Module   : rx_seq_chk
// Purpose  : XOR checksum accumulator over bytes read back from the mux.
//            Only built when RX_SEQ_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef RX_SEQ_CHECKSUM_EN
module rx_seq_chk
  import rx_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_en,
  input  logic [BYTE_W-1:0] i_data,
  output logic [BYTE_W-1:0] o_chk
);

  logic [BYTE_W-1:0] r_chk;

  // Clear wins so a new frame never inherits a stale byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk <= '0;
    end else if (i_clear) begin
      r_chk <= '0;
    end else if (i_en) begin
      r_chk <= r_chk ^ i_data;
    end
  end

  assign o_chk = r_chk;

endmodule
`endif

`default_nettype wire

// File: rtl/rx_frame_sequencer.sv
// ============================================================================
// Module   : rx_frame_sequencer
// Purpose  : Steps the rx 16:1 byte-mux select through a frame and emits
//            byte strobes aligned with the mux registered output.
//            Optional checksum: define RX_SEQ_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_frame_sequencer
  import rx_ctrl_pkg::*;
#(
  parameter int NUM_BYTES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_frame_start,
  output logic              o_frame_ready,
  input  logic              i_byte_en,
  input  logic              i_abort,
  output logic [3:0]        o_sel,
  output logic              o_byte_valid,
  output logic              o_byte_first,
  output logic              o_byte_last,
  output logic              o_frame_done,
  output logic              o_seq_err,
  input  logic              i_err_clr,
  input  logic [BYTE_W-1:0] i_mux_data,
  output logic [BYTE_W-1:0] o_frame_chk
);

  generate
    if (NUM_BYTES < 1 || NUM_BYTES > 16) begin : g_bad_num_bytes
      $error("rx_frame_sequencer: NUM_BYTES must be within 1..16");
    end
  endgenerate

  localparam logic [3:0] c_cnt_last = 4'(NUM_BYTES - 1);

  state_t     r_state;
  logic [3:0] r_sel;
  logic [3:0] r_cnt;
  logic       r_ready;
  logic       r_valid;
  logic       r_first;
  logic       r_last;
  logic       r_done;
  logic       r_seq_err;

  logic       w_issue;
  logic       w_start;
  logic       w_err_set;

  assign w_issue   = (r_state == SEND) && i_byte_en && !i_abort;
  assign w_start   = (r_state == IDLE) && i_frame_start;
  assign w_err_set = (r_state != IDLE) && i_frame_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sel     <= SEL_FIRST;
      r_cnt     <= 4'd0;
      r_ready   <= 1'b1;
      r_valid   <= 1'b0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_seq_err <= 1'b0;
    end else begin
      // Strobes describe the byte the mux registers on this edge.
      r_valid <= w_issue;
      r_first <= w_issue && (r_cnt == 4'd0);
      r_last  <= w_issue && (r_cnt == c_cnt_last);
      r_done  <= 1'b0;

      if (w_err_set) begin
        r_seq_err <= 1'b1;
      end else if (i_err_clr) begin
        r_seq_err <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (i_frame_start) begin
            r_state <= SEND;
            r_ready <= 1'b0;
            r_sel   <= SEL_FIRST;
            r_cnt   <= 4'd0;
          end
        end
        SEND: begin
          if (i_abort) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_sel   <= SEL_FIRST;
            r_cnt   <= 4'd0;
          end else if (i_byte_en) begin
            // The final byte keeps its select so dataout stays stable.
            if (r_cnt == c_cnt_last) begin
              r_state <= DRAIN;
            end else begin
              r_cnt <= r_cnt + 4'd1;
              r_sel <= r_sel - 4'd1;
            end
          end
        end
        DRAIN: begin
          if (i_abort) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_sel   <= SEL_FIRST;
            r_cnt   <= 4'd0;
          end else begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          if (i_abort) begin
            r_sel <= SEL_FIRST;
            r_cnt <= 4'd0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_frame_ready = r_ready;
  assign o_sel         = r_sel;
  assign o_byte_valid  = r_valid;
  assign o_byte_first  = r_first;
  assign o_byte_last   = r_last;
  assign o_frame_done  = r_done;
  assign o_seq_err     = r_seq_err;

`ifdef RX_SEQ_CHECKSUM_EN
  logic [BYTE_W-1:0] w_chk;

  rx_seq_chk u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_start),
    .i_en    (r_valid),
    .i_data  (i_mux_data),
    .o_chk   (w_chk)
  );

  assign o_frame_chk = w_chk;
`else
  logic w_unused_chk;

  assign w_unused_chk = ^{i_mux_data, w_start};
  assign o_frame_chk  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rx_frame_sequencer.sv
// ============================================================================
// Module   : tb_rx_frame_sequencer
// Purpose  : Self-checking bench; four sequencer instances (NUM_BYTES 4,16,1,3)
//            share stimulus, each reads back from its own mux model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rx_frame_sequencer;

  logic clk;
  logic rst_n;
  logic fs, be, ab, ec;

  logic [3:0]      ready, valid, first, last, done, err;
  logic [3:0][3:0] sel;
  logic [3:0][7:0] mux;
  logic [3:0][7:0] chk_out;

  int n_pass;
  int n_total;

  rx_frame_sequencer #(.NUM_BYTES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .i_frame_start(fs), .o_frame_ready(ready[0]),
    .i_byte_en(be), .i_abort(ab), .o_sel(sel[0]), .o_byte_valid(valid[0]),
    .o_byte_first(first[0]), .o_byte_last(last[0]), .o_frame_done(done[0]),
    .o_seq_err(err[0]), .i_err_clr(ec), .i_mux_data(mux[0]), .o_frame_chk(chk_out[0]));

  rx_frame_sequencer #(.NUM_BYTES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .i_frame_start(fs), .o_frame_ready(ready[1]),
    .i_byte_en(be), .i_abort(ab), .o_sel(sel[1]), .o_byte_valid(valid[1]),
    .o_byte_first(first[1]), .o_byte_last(last[1]), .o_frame_done(done[1]),
    .o_seq_err(err[1]), .i_err_clr(ec), .i_mux_data(mux[1]), .o_frame_chk(chk_out[1]));

  rx_frame_sequencer #(.NUM_BYTES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_frame_start(fs), .o_frame_ready(ready[2]),
    .i_byte_en(be), .i_abort(ab), .o_sel(sel[2]), .o_byte_valid(valid[2]),
    .o_byte_first(first[2]), .o_byte_last(last[2]), .o_frame_done(done[2]),
    .o_seq_err(err[2]), .i_err_clr(ec), .i_mux_data(mux[2]), .o_frame_chk(chk_out[2]));

  rx_frame_sequencer #(.NUM_BYTES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .i_frame_start(fs), .o_frame_ready(ready[3]),
    .i_byte_en(be), .i_abort(ab), .o_sel(sel[3]), .o_byte_valid(valid[3]),
    .o_byte_first(first[3]), .o_byte_last(last[3]), .o_frame_done(done[3]),
    .o_seq_err(err[3]), .i_err_clr(ec), .i_mux_data(mux[3]), .o_frame_chk(chk_out[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mux3_byte(input logic [3:0] s);
    case (s)
      4'hF:    return 8'hA5;
      4'hE:    return 8'h0F;
      4'hD:    return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  // Mux models: datain_k = k selected by sel = 16-k, one register of latency.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) mux[i] <= 8'(5'd16 - {1'b0, sel[i]});
    mux[3] <= mux3_byte(sel[3]);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic do_reset;
    fs = 1'b0; be = 1'b0; ab = 1'b0; ec = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst d%0d ready", d), ready[d], 1);
      chk($sformatf("rst d%0d sel", d), sel[d], 4'hF);
      chk($sformatf("rst d%0d strobes", d), {valid[d], first[d], last[d], done[d]}, 0);
      chk($sformatf("rst d%0d seq_err", d), err[d], 0);
      chk($sformatf("rst d%0d frame_chk", d), chk_out[d], 0);
    end
    rst_n = 1'b1;
  endtask

  // Expected behaviour of instance d (n bytes) c cycles after frame_start.
  task automatic chk_frame(input int d, input int n, input int c, input logic [7:0] exp_chk);
    string t;
    int    s;
    t = $sformatf("frm n%0d c%0d", n, c);
    s = (c == 0) ? 15 : ((c <= n) ? 16 - c : 16 - n);
    chk({t, " sel"}, sel[d], s);
    chk({t, " valid"}, valid[d], (c >= 2 && c <= n + 1));
    chk({t, " first"}, first[d], (c == 2));
    chk({t, " last"}, last[d], (c == n + 1));
    chk({t, " done"}, done[d], (c == n + 2));
    chk({t, " ready"}, ready[d], (c == 0 || c >= n + 3));
    if (c >= 2 && c <= n + 1) begin
      if (d == 3) chk({t, " data"}, mux[d], mux3_byte(4'(16 - (c - 1))));
      else        chk({t, " data"}, mux[d], c - 1);
    end
    if (c == n + 2) chk({t, " frame_chk"}, chk_out[d], exp_chk);
  endtask

  typedef struct packed {
    logic [3:0] in;     // {frame_start, byte_en, abort, err_clr}
    logic [3:0] sel;
    logic       sel_chk;
    logic [5:0] out;    // {valid, first, last, done, ready, seq_err}
  } vec_t;

  vec_t tbl [18];

  initial begin
    n_pass = 0; n_total = 0;
    fs = 1'b0; be = 1'b0; ab = 1'b0; ec = 1'b0;
    rst_n = 1'b0;

    tbl[0]  = '{4'b1000, 4'hF, 1'b1, 6'b000010};
    tbl[1]  = '{4'b0100, 4'hF, 1'b1, 6'b000000};
    tbl[2]  = '{4'b0000, 4'hE, 1'b1, 6'b110000};
    tbl[3]  = '{4'b1100, 4'hE, 1'b1, 6'b000000};
    tbl[4]  = '{4'b0000, 4'hD, 1'b1, 6'b100001};
    tbl[5]  = '{4'b0101, 4'hD, 1'b1, 6'b000001};
    tbl[6]  = '{4'b0000, 4'hC, 1'b1, 6'b100000};
    tbl[7]  = '{4'b1101, 4'hC, 1'b1, 6'b000000};
    tbl[8]  = '{4'b0000, 4'hC, 1'b1, 6'b101001};
    tbl[9]  = '{4'b0001, 4'hC, 1'b1, 6'b000101};
    tbl[10] = '{4'b0010, 4'hC, 1'b0, 6'b000010};
    tbl[11] = '{4'b1010, 4'hC, 1'b0, 6'b000010};
    tbl[12] = '{4'b0100, 4'hF, 1'b1, 6'b000000};
    tbl[13] = '{4'b0100, 4'hE, 1'b1, 6'b110000};
    tbl[14] = '{4'b0110, 4'hD, 1'b1, 6'b100000};
    tbl[15] = '{4'b0100, 4'hF, 1'b1, 6'b000010};
    tbl[16] = '{4'b0100, 4'hF, 1'b1, 6'b000010};
    tbl[17] = '{4'b0000, 4'hF, 1'b1, 6'b000010};

    // NUM_BYTES=4: paced byte_en, seq_err set/clear, abort on third issue.
    do_reset();
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (tbl[k].sel_chk) chk($sformatf("vec%0d sel", k), sel[0], tbl[k].sel);
      chk($sformatf("vec%0d valid", k),   valid[0], tbl[k].out[5]);
      chk($sformatf("vec%0d first", k),   first[0], tbl[k].out[4]);
      chk($sformatf("vec%0d last", k),    last[0],  tbl[k].out[3]);
      chk($sformatf("vec%0d done", k),    done[0],  tbl[k].out[2]);
      chk($sformatf("vec%0d ready", k),   ready[0], tbl[k].out[1]);
      chk($sformatf("vec%0d seq_err", k), err[0],   tbl[k].out[0]);
      {fs, be, ab, ec} = tbl[k].in;
    end

    // Full frames with byte_en held high on every instance.
    do_reset();
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
`ifdef RX_SEQ_CHECKSUM_EN
      chk_frame(0, 4,  c, 8'h04);
      chk_frame(1, 16, c, 8'h10);
      chk_frame(2, 1,  c, 8'h01);
      chk_frame(3, 3,  c, 8'h55);
`else
      chk_frame(0, 4,  c, 8'h00);
      chk_frame(1, 16, c, 8'h00);
      chk_frame(2, 1,  c, 8'h00);
      chk_frame(3, 3,  c, 8'h00);
`endif
      fs = (c == 0);
      be = 1'b1;
    end

    // Back-to-back: NUM_BYTES=1 restarts the moment frame_ready returns.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("b2b c%0d valid", c), valid[2], (c == 2 || c == 6));
      chk($sformatf("b2b c%0d ready", c), ready[2], (c == 0 || c == 4));
      chk($sformatf("b2b c%0d seq_err", c), err[2], 0);
      fs = (c == 0 || c == 4);
      be = 1'b1;
    end

    // Asynchronous reset in the middle of a NUM_BYTES=16 frame.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      fs = (c == 0 || c == 3);
      be = 1'b1;
    end
    chk("pre-rst valid", valid[1], 1);
    chk("pre-rst seq_err", err[1], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst sel", sel[1], 4'hF);
    chk("async rst valid", valid[1], 0);
    chk("async rst ready", ready[1], 1);
    chk("async rst seq_err", err[1], 0);
    fs = 1'b0; be = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst ready", ready[1], 1);
    chk("post-rst sel", sel[1], 4'hF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
